pipeline_hazard_ctrl: RTL and testbench

Central sequencing controller for the five-stage LEGv8 pipeline (fetch, decode, execute, memory, writeback).
- Detects load-use hazards between decode and execute and stalls fetch/decode while injecting a bubble into execute.
- Flushes the three younger stages when memory resolves a taken branch (pc_src).
- Tracks per-stage valid bits through reset fill, and keeps saturating cycle/stall/flush counters for bring-up.
- Sits beside the stage modules; owns pc_write, the pipeline-register enables and the flushes.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the LEGv8 pipeline sequencing controller:
// controller states, register address width and stage_valid bit positions.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_W       = 5;
    localparam int ZERO_REG_DEFAULT = 31;
    localparam int STALL_CNT_W      = 2;

    // stage_valid bit positions (pipeline register each bit describes)
    localparam int SV_IF_ID  = 0;
    localparam int SV_ID_EX  = 1;
    localparam int SV_EX_MEM = 2;
    localparam int SV_MEM_WB = 3;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset; sticks at all-ones
// instead of wrapping so long bring-up runs never report small values.
module pipeline_hazard_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the five-stage LEGv8 pipeline: load-use stalls,
// taken-branch flushes, per-stage valid tracking and bring-up counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 32,
    parameter int ZERO_REG       = ZERO_REG_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_read_reg1,
    input  logic [REG_ADDR_W-1:0] id_read_reg2,
    input  logic                  id_uses_reg2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_write_register,
    input  logic                  mem_pc_src,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic [3:0]            stage_valid,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [REG_ADDR_W-1:0]  ZERO_ADDR  = REG_ADDR_W'(ZERO_REG);
    localparam logic [STALL_CNT_W-1:0] STALL_INIT = STALL_CNT_W'(LOAD_USE_STALL - 1);

    hz_state_e              state_reg, state_next;
    logic [3:0]             stage_valid_reg, stage_valid_next;
    logic [STALL_CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

    logic hz;
    logic br;
    logic flush_inc;

    assign hz = ex_mem_read && stage_valid_reg[SV_ID_EX] && (ex_write_register != ZERO_ADDR) &&
                ((ex_write_register == id_read_reg1) ||
                 (id_uses_reg2 && (ex_write_register == id_read_reg2)));
    assign br = mem_pc_src && stage_valid_reg[SV_EX_MEM];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_FILL;
            stage_valid_reg <= '0;
            stall_cnt_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            stage_valid_reg <= stage_valid_next;
            stall_cnt_reg   <= stall_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        stage_valid_next = stage_valid_reg;
        stall_cnt_next   = stall_cnt_reg;
        pc_write         = 1'b1;
        if_id_write      = 1'b1;
        id_ex_bubble     = 1'b0;
        if_id_flush      = 1'b0;
        id_ex_flush      = 1'b0;
        ex_mem_flush     = 1'b0;
        flush_inc        = 1'b0;

        case (state_reg)
            ST_FILL: begin
                stage_valid_next = {stage_valid_reg[2:0], 1'b1};
                if ({stage_valid_reg[2:0], 1'b1} == 4'b1111) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN, ST_STALL: begin
                if (br) begin
                    // Taken branch wins over any hazard and cancels a pending stall.
                    if_id_flush      = 1'b1;
                    id_ex_flush      = 1'b1;
                    ex_mem_flush     = 1'b1;
                    flush_inc        = 1'b1;
                    stage_valid_next = {stage_valid_reg[SV_EX_MEM], 3'b001};
                    state_next       = ST_RUN;
                    stall_cnt_next   = '0;
                end else if (hz || (state_reg == ST_STALL)) begin
                    pc_write         = 1'b0;
                    if_id_write      = 1'b0;
                    id_ex_bubble     = 1'b1;
                    stage_valid_next = {stage_valid_reg[2:1], 1'b0, stage_valid_reg[SV_IF_ID]};
                    if (state_reg == ST_STALL) begin
                        if (stall_cnt_reg <= 2'd1) begin
                            state_next     = ST_RUN;
                            stall_cnt_next = '0;
                        end else begin
                            stall_cnt_next = stall_cnt_reg - 1'b1;
                        end
                    end else if (LOAD_USE_STALL > 1) begin
                        state_next     = ST_STALL;
                        stall_cnt_next = STALL_INIT;
                    end
                end else begin
                    stage_valid_next = {stage_valid_reg[2:0], 1'b1};
                end
            end
            default: begin
                state_next       = ST_FILL;
                stage_valid_next = '0;
                stall_cnt_next   = '0;
            end
        endcase

        // Reset is synchronous, so the state may still be stale this cycle.
        if (reset) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
            flush_inc    = 1'b0;
        end
    end

    assign stage_valid = stage_valid_reg;

    logic             cnt_inc  [3];
    logic [CNT_W-1:0] cnt_vals [3];

    assign cnt_inc[0] = 1'b1;
    assign cnt_inc[1] = !pc_write;
    assign cnt_inc[2] = flush_inc;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            pipeline_hazard_ctrl_sat_counter #(
                .W(CNT_W)
            ) u_cnt (
                .clk  (clk),
                .srst (reset),
                .inc  (cnt_inc[gi]),
                .count(cnt_vals[gi])
            );
        end
    endgenerate

    assign cycle_count = cnt_vals[0];
    assign stall_count = cnt_vals[1];
    assign flush_count = cnt_vals[2];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl: two configurations driven in
// lock-step and compared each cycle against a behavioural pipeline model.
module tb_pipeline_hazard_ctrl;

    localparam int N_CYCLES = 2500;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_read_reg1, id_read_reg2, ex_write_register;
    logic       id_uses_reg2, ex_mem_read, mem_pc_src;

    logic        pc_write_a, if_id_write_a, id_ex_bubble_a, if_id_flush_a, id_ex_flush_a, ex_mem_flush_a;
    logic [3:0]  stage_valid_a;
    logic [31:0] cycle_count_a, stall_count_a, flush_count_a;

    logic        pc_write_b, if_id_write_b, id_ex_bubble_b, if_id_flush_b, id_ex_flush_b, ex_mem_flush_b;
    logic [3:0]  stage_valid_b;
    logic [3:0]  cycle_count_b, stall_count_b, flush_count_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_USE_STALL(1), .CNT_W(32), .ZERO_REG(31)) dut_a (
        .clk(clk), .reset(reset),
        .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2), .id_uses_reg2(id_uses_reg2),
        .ex_mem_read(ex_mem_read), .ex_write_register(ex_write_register), .mem_pc_src(mem_pc_src),
        .pc_write(pc_write_a), .if_id_write(if_id_write_a), .id_ex_bubble(id_ex_bubble_a),
        .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a), .ex_mem_flush(ex_mem_flush_a),
        .stage_valid(stage_valid_a), .cycle_count(cycle_count_a),
        .stall_count(stall_count_a), .flush_count(flush_count_a)
    );

    pipeline_hazard_ctrl #(.LOAD_USE_STALL(3), .CNT_W(4), .ZERO_REG(31)) dut_b (
        .clk(clk), .reset(reset),
        .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2), .id_uses_reg2(id_uses_reg2),
        .ex_mem_read(ex_mem_read), .ex_write_register(ex_write_register), .mem_pc_src(mem_pc_src),
        .pc_write(pc_write_b), .if_id_write(if_id_write_b), .id_ex_bubble(id_ex_bubble_b),
        .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b), .ex_mem_flush(ex_mem_flush_b),
        .stage_valid(stage_valid_b), .cycle_count(cycle_count_b),
        .stall_count(stall_count_b), .flush_count(flush_count_b)
    );

    // Pipeline seen as "is it filled yet", "how many stall cycles remain",
    // a valid bit per pipeline register, and three plain event tallies.
    typedef struct {
        bit       filled;
        int       stall_left;
        bit [3:0] v;
        longint   cyc;
        longint   stl;
        longint   fl;
    } model_t;

    model_t ma, mb;

    function automatic bit model_hz(model_t m);
        return ex_mem_read && m.v[1] && (ex_write_register != 5'd31) &&
               ((ex_write_register == id_read_reg1) ||
                (id_uses_reg2 && (ex_write_register == id_read_reg2)));
    endfunction

    function automatic bit model_br(model_t m);
        return mem_pc_src && m.v[2];
    endfunction

    // {pc_write, if_id_write, bubble, if_id_flush, id_ex_flush, ex_mem_flush}
    function automatic logic [5:0] model_ctrl(model_t m);
        if (reset || !m.filled) return 6'b110000;
        if (model_br(m)) return 6'b110111;
        if (m.stall_left > 0 || model_hz(m)) return 6'b001000;
        return 6'b110000;
    endfunction

    function automatic longint sat_inc(longint x, int cw);
        longint maxv = (longint'(1) << cw) - 1;
        return (x >= maxv) ? maxv : x + 1;
    endfunction

    function automatic model_t model_step(model_t m, int lus, int cw);
        model_t n = m;
        if (reset) begin
            n.filled = 0; n.stall_left = 0; n.v = 4'b0000;
            n.cyc = 0; n.stl = 0; n.fl = 0;
            return n;
        end
        n.cyc = sat_inc(m.cyc, cw);
        if (!m.filled) begin
            n.v = {m.v[2:0], 1'b1};
            n.filled = (n.v == 4'b1111);
        end else if (model_br(m)) begin
            n.v = {m.v[2], 3'b001};
            n.fl = sat_inc(m.fl, cw);
            n.stall_left = 0;
        end else if (m.stall_left > 0 || model_hz(m)) begin
            n.v = {m.v[2], m.v[1], 1'b0, m.v[0]};
            n.stl = sat_inc(m.stl, cw);
            n.stall_left = (m.stall_left > 0) ? m.stall_left - 1 : lus - 1;
        end else begin
            n.v = {m.v[2:0], 1'b1};
        end
        return n;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] rand_reg();
        case ($urandom_range(3))
            0:       return 5'd9;
            1:       return 5'd31;
            2:       return 5'd5;
            default: return 5'($urandom_range(31));
        endcase
    endfunction

    initial begin
        logic [5:0] exp_a, exp_b;
        ma = '{filled: 0, stall_left: 0, v: 4'b0, cyc: 0, stl: 0, fl: 0};
        mb = ma;
        reset = 1'b1;
        id_read_reg1 = '0; id_read_reg2 = '0; ex_write_register = '0;
        id_uses_reg2 = 1'b0; ex_mem_read = 1'b0; mem_pc_src = 1'b0;

        for (int c = 0; c < N_CYCLES; c++) begin
            @(posedge clk);
            #1;
            reset             = (c < 2) || ($urandom_range(249) == 0);
            id_read_reg1      = rand_reg();
            id_read_reg2      = rand_reg();
            ex_write_register = rand_reg();
            id_uses_reg2      = 1'($urandom_range(1));
            ex_mem_read       = ($urandom_range(9) < 6);
            mem_pc_src        = (c > 6 && c < 12) ? 1'b0 : ($urandom_range(11) == 0);
            #2;
            exp_a = model_ctrl(ma);
            exp_b = model_ctrl(mb);
            check_eq("a_ctrl", 64'({pc_write_a, if_id_write_a, id_ex_bubble_a,
                                    if_id_flush_a, id_ex_flush_a, ex_mem_flush_a}), 64'(exp_a));
            check_eq("a_stage_valid", 64'(stage_valid_a), 64'(ma.v));
            check_eq("a_cycle_count", 64'(cycle_count_a), 64'(ma.cyc));
            check_eq("a_stall_count", 64'(stall_count_a), 64'(ma.stl));
            check_eq("a_flush_count", 64'(flush_count_a), 64'(ma.fl));
            check_eq("b_ctrl", 64'({pc_write_b, if_id_write_b, id_ex_bubble_b,
                                    if_id_flush_b, id_ex_flush_b, ex_mem_flush_b}), 64'(exp_b));
            check_eq("b_stage_valid", 64'(stage_valid_b), 64'(mb.v));
            check_eq("b_cycle_count", 64'(cycle_count_b), 64'(mb.cyc));
            check_eq("b_stall_count", 64'(stall_count_b), 64'(mb.stl));
            check_eq("b_flush_count", 64'(flush_count_b), 64'(mb.fl));
            $display("cyc %0d rst=%0b rd=%0b wr=%0d r1=%0d r2=%0d u2=%0b br=%0b | a ctrl=%b sv=%b | b ctrl=%b sv=%b stl=%0d",
                     c, reset, ex_mem_read, ex_write_register, id_read_reg1, id_read_reg2,
                     id_uses_reg2, mem_pc_src, exp_a, ma.v, exp_b, mb.v, mb.stl);
            ma = model_step(ma, 1, 32);
            mb = model_step(mb, 3, 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
